// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per clock,
// with a start/busy/done handshake and sign correction applied in a final FIX cycle.
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2*W-1:0]  acc_r;
  logic [W-1:0]    opnd_r;
  logic            div_r;
  logic            sa_r;
  logic            neg_r;

  logic [W-1:0]    abs_a_s;
  logic [W-1:0]    abs_b_s;
  logic            sa_s;
  logic            sb_s;
  logic [W:0]      add_s;
  logic [W:0]      rem_cand_s;
  logic [W-1:0]    diff_s;
  logic [2*W-1:0]  mul_next_s;
  logic [2*W-1:0]  div_next_s;
  logic [2*W-1:0]  prod_neg_s;
  logic [W-1:0]    fix_hi_s;
  logic [W-1:0]    fix_lo_s;
  logic            fix_dbz_s;

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return ~x + W'(1);
  endfunction

  // Operand magnitudes and sign flags for the load in IDLE.
  always_comb begin
    sa_s    = op[0] & a[W-1];
    sb_s    = op[0] & b[W-1];
    abs_a_s = sa_s ? neg_w(a) : a;
    abs_b_s = sb_s ? neg_w(b) : b;
  end

  // One iteration of each algorithm; divide keeps remainder in acc[2W-1:W], quotient below.
  always_comb begin
    add_s      = {1'b0, acc_r[2*W-1:W]} + {1'b0, opnd_r};
    mul_next_s = acc_r[0] ? {add_s, acc_r[W-1:1]} : {1'b0, acc_r[2*W-1:1]};
    rem_cand_s = acc_r[2*W-1:W-1];
    diff_s     = rem_cand_s[W-1:0] - opnd_r;
    if (rem_cand_s >= {1'b0, opnd_r}) begin
      div_next_s = {diff_s, acc_r[W-2:0], 1'b1};
    end else begin
      div_next_s = {acc_r[2*W-2:0], 1'b0};
    end
  end

  // Sign correction; divide-by-zero skips the quotient fix, and the remainder fix restores a.
  always_comb begin
    prod_neg_s = ~acc_r + {{(2*W-1){1'b0}}, 1'b1};
    fix_hi_s   = {W{1'b0}};
    fix_lo_s   = {W{1'b0}};
    fix_dbz_s  = 1'b0;
    if (div_r) begin
      fix_hi_s = sa_r ? neg_w(acc_r[2*W-1:W]) : acc_r[2*W-1:W];
      if (opnd_r == {W{1'b0}}) begin
        fix_lo_s  = {W{1'b1}};
        fix_dbz_s = 1'b1;
      end else begin
        fix_lo_s  = neg_r ? neg_w(acc_r[W-1:0]) : acc_r[W-1:0];
        fix_dbz_s = 1'b0;
      end
    end else begin
      fix_hi_s  = neg_r ? prod_neg_s[2*W-1:W] : acc_r[2*W-1:W];
      fix_lo_s  = neg_r ? prod_neg_s[W-1:0]   : acc_r[W-1:0];
      fix_dbz_s = 1'b0;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {(2*W){1'b0}};
      opnd_r      <= {W{1'b0}};
      div_r       <= 1'b0;
      sa_r        <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= {W{1'b0}};
      lo          <= {W{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_r   <= op[1];
            sa_r    <= sa_s;
            neg_r   <= sa_s ^ sb_s;
            cnt_r   <= CW'(W - 1);
            acc_r   <= op[1] ? {{W{1'b0}}, abs_a_s} : {{W{1'b0}}, abs_b_s};
            opnd_r  <= op[1] ? abs_b_s : abs_a_s;
            busy    <= 1'b1;
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          done  <= 1'b0;
          acc_r <= div_r ? div_next_s : mul_next_s;
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        FIX: begin
          hi          <= fix_hi_s;
          lo          <= fix_lo_s;
          div_by_zero <= fix_dbz_s;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;
  logic        exp_dbz = 1'b0;

  muldiv_unit #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {busy,done,hi,lo,dbz}=%h expected %h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo, div_by_zero} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        p = {32'h0, x} * {32'h0, y};
        return {p, 1'b0};
      end
      2'b01: begin
        p = 64'(sx * sy);
        return {p, 1'b0};
      end
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF, 1'b1};
        return {x % y, x / y, 1'b0};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF, 1'b1};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0], 1'b0};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op now (caller is between edges), checks every busy cycle, returns in the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit inject);
    logic [64:0] res;
    res = model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    for (int i = 0; i <= 32; i++) begin
      check_eq({tag, "_busy"}, {busy, done, hi, lo, div_by_zero},
               {1'b1, 1'b0, exp_hi, exp_lo, exp_dbz});
      start = (inject && i == 5) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    {exp_hi, exp_lo, exp_dbz} = res;
    check_eq({tag, "_done"}, {busy, done, hi, lo, div_by_zero},
             {1'b0, 1'b1, exp_hi, exp_lo, exp_dbz});
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_eq(tag, {busy, done, hi, lo, div_by_zero}, {1'b0, 1'b0, exp_hi, exp_lo, exp_dbz});
    end
  endtask

  initial begin
    #23;
    check_eq("reset", {busy, done, hi, lo, div_by_zero}, 67'h0);
    #9 rst_n = 1'b1;
    idle("post_reset", 1);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("t1_value", {2'b01, hi, lo, div_by_zero}, {2'b01, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    idle("t1_idle", 2);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check_eq("t2_value", {2'b01, hi, lo, div_by_zero}, {2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
    idle("t2_idle", 1);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("t3_value", {2'b01, hi, lo, div_by_zero}, {2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    idle("t3_idle", 1);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0, 1'b0);
    check_eq("t4_value", {2'b01, hi, lo, div_by_zero}, {2'b01, 32'h64, 32'hFFFF_FFFF, 1'b1});
    run_op("multu_b2b", 2'b00, 32'd2, 32'd3, 1'b0);
    check_eq("t4b_value", {2'b01, hi, lo, div_by_zero}, {2'b01, 32'h0, 32'd6, 1'b0});
    idle("t4_idle", 1);
    run_op("div_ovf_inject", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_eq("t5_value", {2'b01, hi, lo, div_by_zero}, {2'b01, 32'h0, 32'h8000_0000, 1'b0});
    idle("t5_idle", 1);

    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp_hi = 32'h0; exp_lo = 32'h0; exp_dbz = 1'b0;
    check_eq("abort_reset", {busy, done, hi, lo, div_by_zero}, 67'h0);
    repeat (2) @(posedge clk);
    #1 check_eq("abort_hold", {busy, done, hi, lo, div_by_zero}, 67'h0);
    rst_n = 1'b1;
    idle("abort_idle", 1);
    run_op("divu_1000_7", 2'b10, 32'd1000, 32'd7, 1'b0);
    check_eq("t6_value", {2'b01, hi, lo, div_by_zero}, {2'b01, 32'd6, 32'd142, 1'b0});
    run_op("multu_4_4_b2b", 2'b00, 32'd4, 32'd4, 1'b0);
    check_eq("t6b_value", {2'b01, hi, lo, div_by_zero}, {2'b01, 32'h0, 32'd16, 1'b0});
    idle("t6_idle", 2);

    for (int k = 0; k < 40; k++) begin
      run_op("rand", 2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle("rand_idle", 1);
    end
    idle("final_idle", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
